traffic_lamp_guard: RTL and testbench
=====================================

# traffic_lamp_guard

Safety stage directly downstream of the two-approach traffic light controller. It registers the controller's light_A/light_B codes, checks them for illegal encodings, conflicting greens, bad colour sequences and (optionally) a stuck controller, and drives the physical lamp outputs. On any fault it latches a fault code and forces both approaches to flashing red until an operator clear.

## Interface
- FILTER_CYC, 2: consecutive clocks a condition or new input value must persist before it counts (≥1).
- ALLRED_TICKS, 2: ticks of all-red after reset or a fault clear before following the controller.
- WDOG_TICKS, 8: ticks without a qualified input change before a stuck fault; active only with the watchdog macro.
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- tick  in  1  one-clk 1 Hz timebase strobe.
- light_A  in  3  controller code for approach A: bit0 green, bit1 yellow, bit2 red.
- light_B  in  3  controller code for approach B, same encoding.
- clear_fault  in  1  single-cycle operator clear.
- lamp_A  out  3  lamp drive for A, same encoding; 3'b000 = dark.
- lamp_B  out  3  lamp drive for B.
- fault  out  1  high while in FAULT.
- fault_code  out  3  0 none, 1 illegal code, 2 conflict, 3 sequence, 4 stuck.

## Operation
- States: ALLRED, NORMAL, FAULT. Reset enters ALLRED.
- Illegal: a code is anything not one-hot. Conflict: neither approach red.
- Raw conditions feed FILTER_CYC-deep persistence counters. A fault is raised only after FILTER_CYC consecutive true cycles.
- Qualified value per approach: updates when the raw input has been identical for FILTER_CYC cycles.
- Legal qualified transitions are G→Y, Y→R and R→G. Any other change is a sequence fault.
- ALLRED:
  - lamps 3'b100/3'b100; tick counter counts ticks.
  - Qualified values track the inputs with no sequence check, and fault checks are off.
  - Leave for NORMAL when the count reaches ALLRED_TICKS and the qualified inputs are legal and non-conflicting. Otherwise hold in ALLRED with the count saturated.
- NORMAL:
  - lamps = qualified values; all checks active.
  - First detected fault → FAULT, fault_code latched.
  - Priority if several fire in the same cycle: 1 > 2 > 3 > 4.
- FAULT:
  - fault=1; flash phase starts at 1 on entry and toggles on each tick.
  - phase 1 → both lamps 3'b100; phase 0 → both 3'b000.
  - Further detections are ignored and the first code holds.
  - clear_fault → ALLRED: fault_code=0, counters cleared. clear_fault in other states is ignored.
- Simultaneous events:
  - rst beats everything.
  - In FAULT, clear_fault beats a new detection.
  - In NORMAL, a detection beats a tick.

## Timing
- Reset values: lamp_A=lamp_B=3'b100, fault=0, fault_code=0, state ALLRED, flash phase 1, all counters 0.
- All outputs are registered.
- NORMAL input-to-lamp latency: FILTER_CYC+1 clocks from the first cycle of a stable new code.
- Fault latency: the condition persists FILTER_CYC clocks, then fault and fault_code assert on the next edge and the lamps go red on that same edge.
- Counter widths are $clog2 of their limit+1. All counters saturate and never wrap.
- The reset mid-FAULT or mid-ALLRED behaviour is identical to power-up.

## Configuration
- TRAFFIC_GUARD_WDOG_EN defined:
  - In NORMAL, a tick counter clears on any qualified change of either approach.
  - Reaching WDOG_TICKS raises fault_code 4.
- Undefined: no watchdog logic; code 4 is never produced and WDOG_TICKS is unused.

## Structure
- Shared package traffic_pkg holds:
  - LAMP_GREEN=3'b001, LAMP_YELLOW=3'b010, LAMP_RED=3'b100, LAMP_DARK=3'b000.
  - Guard state encoding.
  - Fault-code constants.
- Sub-module lamp_seq_checker, instantiated once per approach. It contains the persistence filter, the qualified register, and the illegal/sequence flags.
- The conflict check, FSM, flash and watchdog live in the top level.

## Test plan
- Reset with A=001 and B=100 held → lamps 100/100 for 2 ticks, then lamp_A=001 and lamp_B=100 three clocks after entering NORMAL.
- In NORMAL, drive A=011 for 2 clocks → fault=1, fault_code=1, lamps 100/100, going dark on the next tick and red on the one after.
- Drive A=001 and B=001 for 2 clocks → fault_code=2. A single-clock 001/001 glitch → no fault.
- Drive A 001→100, skipping yellow → fault_code=3. A 001→010→100 sequence → no fault.
- Pulse clear_fault with inputs 100/100 → fault=0, fault_code=0, all-red for 2 ticks, then lamps follow the inputs.
- With TRAFFIC_GUARD_WDOG_EN, hold A=001/B=100 for 8 ticks in NORMAL → fault_code=4. Without the macro → no fault.

Source files
------------

// File: rtl/traffic_pkg.sv
// ============================================================================
// Module      : traffic_pkg
// Description : Shared lamp encodings, guard state encoding, fault codes and
//               small helpers for the traffic lamp guard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package traffic_pkg;

   // Lamp encoding: bit0 green, bit1 yellow, bit2 red, all-zero is dark
   localparam logic [2:0] LAMP_GREEN  = 3'b001;
   localparam logic [2:0] LAMP_YELLOW = 3'b010;
   localparam logic [2:0] LAMP_RED    = 3'b100;
   localparam logic [2:0] LAMP_DARK   = 3'b000;

   typedef enum logic [1:0] {
      ST_ALLRED = 2'd0,
      ST_NORMAL = 2'd1,
      ST_FAULT  = 2'd2
   } guard_state_t;

   localparam logic [2:0] FAULT_NONE     = 3'd0;
   localparam logic [2:0] FAULT_ILLEGAL  = 3'd1;
   localparam logic [2:0] FAULT_CONFLICT = 3'd2;
   localparam logic [2:0] FAULT_SEQUENCE = 3'd3;
   localparam logic [2:0] FAULT_STUCK    = 3'd4;

   // A lamp code is legal only when exactly one colour is lit
   function automatic logic is_onehot3(input logic [2:0] code);
      return (code == LAMP_GREEN) || (code == LAMP_YELLOW) || (code == LAMP_RED);
   endfunction

   // Allowed colour progression: green -> yellow -> red -> green
   function automatic logic legal_step(input logic [2:0] from_code, input logic [2:0] to_code);
      return ((from_code == LAMP_GREEN)  && (to_code == LAMP_YELLOW)) ||
             ((from_code == LAMP_YELLOW) && (to_code == LAMP_RED))    ||
             ((from_code == LAMP_RED)    && (to_code == LAMP_GREEN));
   endfunction

endpackage

`default_nettype wire

// File: rtl/traffic_lamp_guard_seq_checker.sv
// ============================================================================
// Module      : lamp_seq_checker
// Description : Per-approach persistence filter, qualified lamp register and
//               illegal-code / bad-sequence flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lamp_seq_checker
   import traffic_pkg::*;
#(
   parameter int FILTER_CYC = 2
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] code,
   input  logic       seq_en,
   input  logic       clear,
   output logic [2:0] qual,
   output logic       qual_chg,
   output logic       illegal,
   output logic       seq_err
);

   localparam int            CW       = $clog2(FILTER_CYC + 1);
   localparam logic [CW-1:0] FILT_MAX = CW'(FILTER_CYC);

   logic [2:0]    prev;
   logic [CW-1:0] run_cnt;
   logic [CW-1:0] ill_cnt;
   logic [CW-1:0] run_next;
   logic [CW-1:0] ill_next;
   logic          qualify;

   // Next values of the stability run and the illegal-code persistence count
   always_comb begin
      run_next = CW'(1);
      if ((run_cnt != '0) && (code == prev)) begin
         run_next = (run_cnt == FILT_MAX) ? run_cnt : run_cnt + CW'(1);
      end
      ill_next = '0;
      if (!is_onehot3(code)) begin
         ill_next = (ill_cnt == FILT_MAX) ? ill_cnt : ill_cnt + CW'(1);
      end
      qualify = (run_next == FILT_MAX) && (code != qual);
   end

   // Filter state, qualified value and registered fault flags
   always_ff @(posedge clk) begin
      if (rst) begin
         prev     <= LAMP_DARK;
         run_cnt  <= '0;
         ill_cnt  <= '0;
         qual     <= LAMP_RED;
         qual_chg <= 1'b0;
         illegal  <= 1'b0;
         seq_err  <= 1'b0;
      end else begin
         prev     <= code;
         run_cnt  <= run_next;
         qual_chg <= qualify;
         if (qualify) begin
            qual <= code;
         end
         // The sequence flag fires on the same edge the bad value qualifies
         seq_err <= qualify && seq_en && !clear && !legal_step(qual, code);
         if (clear) begin
            ill_cnt <= '0;
            illegal <= 1'b0;
         end else begin
            ill_cnt <= ill_next;
            illegal <= (ill_next == FILT_MAX);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/traffic_lamp_guard.sv
// ============================================================================
// Module      : traffic_lamp_guard
// Description : Safety stage behind the two-approach traffic light controller.
//               Filters the controller codes, detects illegal codes, conflicts,
//               bad sequences and (optionally) a stuck controller, and drives
//               the lamps; any fault latches a code and flashes red.
//               Optional watchdog: define TRAFFIC_GUARD_WDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_lamp_guard
   import traffic_pkg::*;
#(
   parameter int FILTER_CYC   = 2,
   parameter int ALLRED_TICKS = 2,
   parameter int WDOG_TICKS   = 8
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic [2:0] light_A,
   input  logic [2:0] light_B,
   input  logic       clear_fault,
   output logic [2:0] lamp_A,
   output logic [2:0] lamp_B,
   output logic       fault,
   output logic [2:0] fault_code
);

   localparam int              FW      = $clog2(FILTER_CYC + 1);
   localparam logic [FW-1:0]   FILT_MAX = FW'(FILTER_CYC);
   localparam int              AW      = (ALLRED_TICKS > 0) ? $clog2(ALLRED_TICKS + 1) : 1;
   localparam logic [AW-1:0]   AR_MAX  = AW'(ALLRED_TICKS);

   guard_state_t  state;
   logic [AW-1:0] allred_cnt;
   logic          phase;

   logic [2:0]    qual_a;
   logic [2:0]    qual_b;
   logic          qchg_a;
   logic          qchg_b;
   logic          illegal_a;
   logic          illegal_b;
   logic          seq_a;
   logic          seq_b;
   logic          seq_en;
   logic          clr_evt;

   logic [FW-1:0] conf_cnt;
   logic [FW-1:0] conf_next;
   logic          conflict;
   logic          stuck;
   logic          allred_ok;
   logic [2:0]    det_code;

   assign seq_en  = (state == ST_NORMAL);
   assign clr_evt = (state == ST_FAULT) && clear_fault;

   lamp_seq_checker #(.FILTER_CYC(FILTER_CYC)) u_chk_a (
      .clk      (clk),
      .rst      (rst),
      .code     (light_A),
      .seq_en   (seq_en),
      .clear    (clr_evt),
      .qual     (qual_a),
      .qual_chg (qchg_a),
      .illegal  (illegal_a),
      .seq_err  (seq_a)
   );

   lamp_seq_checker #(.FILTER_CYC(FILTER_CYC)) u_chk_b (
      .clk      (clk),
      .rst      (rst),
      .code     (light_B),
      .seq_en   (seq_en),
      .clear    (clr_evt),
      .qual     (qual_b),
      .qual_chg (qchg_b),
      .illegal  (illegal_b),
      .seq_err  (seq_b)
   );

   // Conflict persistence: neither raw input shows red
   always_comb begin
      conf_next = '0;
      if (!light_A[2] && !light_B[2]) begin
         conf_next = (conf_cnt == FILT_MAX) ? conf_cnt : conf_cnt + FW'(1);
      end
   end

   // Conflict counter and its registered flag
   always_ff @(posedge clk) begin
      if (rst || clr_evt) begin
         conf_cnt <= '0;
         conflict <= 1'b0;
      end else begin
         conf_cnt <= conf_next;
         conflict <= (conf_next == FILT_MAX);
      end
   end

`ifdef TRAFFIC_GUARD_WDOG_EN
   localparam int            WW       = (WDOG_TICKS > 0) ? $clog2(WDOG_TICKS + 1) : 1;
   localparam logic [WW-1:0] WDOG_MAX = WW'(WDOG_TICKS);
   logic [WW-1:0] wdog_cnt;

   // Stuck-controller watchdog: ticks without a qualified change in NORMAL
   always_ff @(posedge clk) begin
      if (rst) begin
         wdog_cnt <= '0;
      end else if ((state != ST_NORMAL) || qchg_a || qchg_b) begin
         wdog_cnt <= '0;
      end else if (tick && (wdog_cnt != WDOG_MAX)) begin
         wdog_cnt <= wdog_cnt + WW'(1);
      end
   end

   assign stuck = (wdog_cnt == WDOG_MAX);
`else
   // No watchdog: a stuck fault can never be raised (the limit is always >= 0)
   localparam logic WDOG_ACTIVE = (WDOG_TICKS < 0);
   assign stuck = WDOG_ACTIVE;

   logic unused_qchg;
   assign unused_qchg = qchg_a ^ qchg_b;
`endif

   // Qualified inputs are safe to hand over to the controller
   assign allred_ok = is_onehot3(qual_a) && is_onehot3(qual_b) && (qual_a[2] || qual_b[2]);

   // Detection priority: illegal > conflict > sequence > stuck
   always_comb begin
      det_code = FAULT_NONE;
      if (illegal_a || illegal_b) begin
         det_code = FAULT_ILLEGAL;
      end else if (conflict) begin
         det_code = FAULT_CONFLICT;
      end else if (seq_a || seq_b) begin
         det_code = FAULT_SEQUENCE;
      end else if (stuck) begin
         det_code = FAULT_STUCK;
      end
   end

   // Guard FSM with registered lamp and fault outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_ALLRED;
         allred_cnt <= '0;
         phase      <= 1'b1;
         lamp_A     <= LAMP_RED;
         lamp_B     <= LAMP_RED;
         fault      <= 1'b0;
         fault_code <= FAULT_NONE;
      end else begin
         case (state)
            ST_ALLRED: begin
               lamp_A <= LAMP_RED;
               lamp_B <= LAMP_RED;
               if (tick && (allred_cnt != AR_MAX)) begin
                  allred_cnt <= allred_cnt + AW'(1);
               end
               if ((allred_cnt == AR_MAX) && allred_ok) begin
                  state <= ST_NORMAL;
               end
            end
            ST_NORMAL: begin
               if (det_code != FAULT_NONE) begin
                  state      <= ST_FAULT;
                  fault      <= 1'b1;
                  fault_code <= det_code;
                  phase      <= 1'b1;
                  lamp_A     <= LAMP_RED;
                  lamp_B     <= LAMP_RED;
               end else begin
                  lamp_A <= qual_a;
                  lamp_B <= qual_b;
               end
            end
            ST_FAULT: begin
               if (clear_fault) begin
                  state      <= ST_ALLRED;
                  fault      <= 1'b0;
                  fault_code <= FAULT_NONE;
                  allred_cnt <= '0;
                  phase      <= 1'b1;
                  lamp_A     <= LAMP_RED;
                  lamp_B     <= LAMP_RED;
               end else if (tick) begin
                  phase  <= ~phase;
                  lamp_A <= phase ? LAMP_DARK : LAMP_RED;
                  lamp_B <= phase ? LAMP_DARK : LAMP_RED;
               end
            end
            default: begin
               state  <= ST_ALLRED;
               lamp_A <= LAMP_RED;
               lamp_B <= LAMP_RED;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_traffic_lamp_guard.sv
// ============================================================================
// Module      : tb_traffic_lamp_guard
// Description : Directed self-checking bench for traffic_lamp_guard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_traffic_lamp_guard;

   logic       clk;
   logic       rst;
   logic       tick;
   logic [2:0] light_A;
   logic [2:0] light_B;
   logic       clear_fault;
   logic [2:0] lamp_A;
   logic [2:0] lamp_B;
   logic       fault;
   logic [2:0] fault_code;

   int vectors;
   int miscompares;

   traffic_lamp_guard dut (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .light_A     (light_A),
      .light_B     (light_B),
      .clear_fault (clear_fault),
      .lamp_A      (lamp_A),
      .lamp_B      (lamp_B),
      .fault       (fault),
      .fault_code  (fault_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n rising edges, leaving time 1 unit past the last edge
   task automatic clk_n(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_tick();
      tick = 1'b1;
      clk_n(1);
      tick = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Clear a latched fault with all-red inputs and wait back into NORMAL
   task automatic recover(input string tag);
      light_A = 3'b100;
      light_B = 3'b100;
      clk_n(3);
      clear_fault = 1'b1;
      clk_n(1);
      clear_fault = 1'b0;
      chk({tag, "_clr_fault"}, 32'(fault), 32'd0);
      chk({tag, "_clr_code"}, 32'(fault_code), 32'd0);
      chk({tag, "_clr_lampA"}, 32'(lamp_A), 32'b100);
      do_tick();
      do_tick();
      clk_n(3);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      tick        = 1'b0;
      clear_fault = 1'b0;
      light_A     = 3'b001;
      light_B     = 3'b100;

      // Reset state
      clk_n(3);
      chk("rst_lampA", 32'(lamp_A), 32'b100);
      chk("rst_lampB", 32'(lamp_B), 32'b100);
      chk("rst_fault", 32'(fault), 32'd0);
      chk("rst_code", 32'(fault_code), 32'd0);

      // All-red for two ticks, then follow the controller
      rst = 1'b0;
      clk_n(4);
      chk("allred_lampA_t0", 32'(lamp_A), 32'b100);
      do_tick();
      chk("allred_lampA_t1", 32'(lamp_A), 32'b100);
      do_tick();
      chk("allred_lampA_t2", 32'(lamp_A), 32'b100);
      clk_n(3);
      chk("normal_lampA", 32'(lamp_A), 32'b001);
      chk("normal_lampB", 32'(lamp_B), 32'b100);
      chk("normal_fault", 32'(fault), 32'd0);

      // Illegal code on A for two clocks
      light_A = 3'b011;
      clk_n(2);
      light_A = 3'b001;
      chk("ill_before", 32'(fault), 32'd0);
      clk_n(1);
      chk("ill_fault", 32'(fault), 32'd1);
      chk("ill_code", 32'(fault_code), 32'd1);
      chk("ill_lampA", 32'(lamp_A), 32'b100);
      chk("ill_lampB", 32'(lamp_B), 32'b100);
      do_tick();
      chk("flash_darkA", 32'(lamp_A), 32'b000);
      chk("flash_darkB", 32'(lamp_B), 32'b000);
      do_tick();
      chk("flash_redA", 32'(lamp_A), 32'b100);
      clear_fault = 1'b0;
      recover("rec1");
      chk("rec1_normal_lampA", 32'(lamp_A), 32'b100);

      // Lamps follow a new code after FILTER_CYC+1 clocks
      light_A = 3'b001;
      clk_n(2);
      chk("lat_early", 32'(lamp_A), 32'b100);
      clk_n(1);
      chk("lat_exact", 32'(lamp_A), 32'b001);

      // Single-clock conflict glitch is filtered out
      light_B = 3'b001;
      clk_n(1);
      light_B = 3'b100;
      clk_n(4);
      chk("glitch_fault", 32'(fault), 32'd0);
      chk("glitch_lampB", 32'(lamp_B), 32'b100);

      // Two-clock conflict raises code 2
      light_B = 3'b001;
      clk_n(2);
      light_B = 3'b100;
      chk("conf_before", 32'(fault), 32'd0);
      clk_n(1);
      chk("conf_fault", 32'(fault), 32'd1);
      chk("conf_code", 32'(fault_code), 32'd2);
      chk("conf_lampB", 32'(lamp_B), 32'b100);
      recover("rec2");

      // Legal G -> Y -> R progression on A
      light_A = 3'b001;
      clk_n(3);
      chk("seq_green", 32'(lamp_A), 32'b001);
      light_A = 3'b010;
      clk_n(3);
      chk("seq_yellow", 32'(lamp_A), 32'b010);
      light_A = 3'b100;
      clk_n(3);
      chk("seq_red", 32'(lamp_A), 32'b100);
      chk("seq_ok_fault", 32'(fault), 32'd0);

      // Green straight to red is a sequence fault
      light_A = 3'b001;
      clk_n(3);
      light_A = 3'b100;
      clk_n(2);
      chk("skip_before", 32'(fault), 32'd0);
      clk_n(1);
      chk("skip_fault", 32'(fault), 32'd1);
      chk("skip_code", 32'(fault_code), 32'd3);

      // Reset in FAULT behaves like power-up
      rst = 1'b1;
      clk_n(2);
      chk("rst2_fault", 32'(fault), 32'd0);
      chk("rst2_code", 32'(fault_code), 32'd0);
      chk("rst2_lampA", 32'(lamp_A), 32'b100);
      rst = 1'b0;
      clk_n(3);
      do_tick();
      do_tick();
      clk_n(3);

      // Stuck controller: no qualified change for WDOG_TICKS ticks
      light_A = 3'b001;
      clk_n(3);
      chk("wd_start_lampA", 32'(lamp_A), 32'b001);
      repeat (8) do_tick();
      clk_n(2);
`ifdef TRAFFIC_GUARD_WDOG_EN
      chk("wd_fault", 32'(fault), 32'd1);
      chk("wd_code", 32'(fault_code), 32'd4);
      chk("wd_lampA", 32'(lamp_A), 32'b100);
`else
      chk("wd_fault", 32'(fault), 32'd0);
      chk("wd_code", 32'(fault_code), 32'd0);
      chk("wd_lampA", 32'(lamp_A), 32'b001);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
